// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: parametrised valid/ready pipeline stage with optional skid entry, flush and stall counter
module pipe_stage_buf #(
  parameter int DATA_W = 64,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              up_valid_i,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              up_ready_o,
  output logic              dn_valid_o,
  output logic [DATA_W-1:0] dn_data_o,
  input  logic              dn_ready_i,
  output logic [1:0]        occ_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);
  localparam logic [1:0] EMPTY = 2'd0, HALF = 2'd1, FULL = 2'd2;
  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d, skid;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              push, pop, dn_valid;
  assign push = up_valid_i & up_ready_o;
  assign pop  = dn_valid & dn_ready_i;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      main_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      stall_q <= stall_d;
    end
  end
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    if (flush_i) begin
      state_d = EMPTY;
      main_d  = '0;
    end else begin
      case (state_q)
        EMPTY: if (push) begin
          state_d = HALF;
          main_d  = up_data_i;
        end
        HALF: begin
          if (push && pop) main_d = up_data_i;
          else if (push) state_d = (SKID != 0) ? FULL : HALF;
          else if (pop) state_d = EMPTY;
        end
        FULL: if (pop) begin
          state_d = HALF;
          main_d  = skid;
        end
        default: state_d = EMPTY;
      endcase
    end
  end
  // saturate instead of wrapping; flush cycles are not counted as stalls
  assign stall_d = (dn_valid && !dn_ready_i && !flush_i && !(&stall_q)) ? stall_q + CNT_W'(1) : stall_q;
  always_comb begin
    dn_valid    = state_q != EMPTY;
    dn_valid_o  = dn_valid;
    dn_data_o   = dn_valid ? main_q : '0;
    occ_o       = state_q;
    stall_cnt_o = stall_q;
  end
  generate
    if (SKID != 0) begin : g_skid
      logic [DATA_W-1:0] skid_q;
      logic              rdy_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          skid_q <= '0;
          rdy_q  <= 1'b1;
        end else begin
          if (flush_i) skid_q <= '0;
          else if (state_q == HALF && push && !pop) skid_q <= up_data_i;
          rdy_q <= state_d != FULL;
        end
      end
      assign skid       = skid_q;
      assign up_ready_o = rdy_q;
    end else begin : g_noskid
      assign skid       = '0;
      assign up_ready_o = !dn_valid | dn_ready_i;
    end
  endgenerate
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: scoreboard bench for SKID=1, SKID=0 and narrow-counter instances
module tb_pipe_stage_buf;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic a_flush = 0, a_uv = 0, a_ur, a_dv, a_dr = 0;
  logic [63:0] a_ud = '0, a_dd;
  logic [1:0] a_occ;
  logic [15:0] a_st;
  logic b_flush = 0, b_uv = 0, b_ur, b_dv, b_dr = 0;
  logic [63:0] b_ud = '0, b_dd;
  logic [1:0] b_occ;
  logic [15:0] b_st;
  logic c_flush = 0, c_uv = 0, c_ur, c_dv, c_dr = 0;
  logic [7:0] c_ud = '0, c_dd;
  logic [1:0] c_occ;
  logic [3:0] c_st;
  pipe_stage_buf u_a (.clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush), .up_valid_i(a_uv), .up_data_i(a_ud),
    .up_ready_o(a_ur), .dn_valid_o(a_dv), .dn_data_o(a_dd), .dn_ready_i(a_dr), .occ_o(a_occ), .stall_cnt_o(a_st));
  pipe_stage_buf #(.SKID(0)) u_b (.clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush), .up_valid_i(b_uv), .up_data_i(b_ud),
    .up_ready_o(b_ur), .dn_valid_o(b_dv), .dn_data_o(b_dd), .dn_ready_i(b_dr), .occ_o(b_occ), .stall_cnt_o(b_st));
  pipe_stage_buf #(.DATA_W(8), .CNT_W(4)) u_c (.clk_i(clk), .rst_ni(rst_n), .flush_i(c_flush), .up_valid_i(c_uv), .up_data_i(c_ud),
    .up_ready_o(c_ur), .dn_valid_o(c_dv), .dn_data_o(c_dd), .dn_ready_i(c_dr), .occ_o(c_occ), .stall_cnt_o(c_st));
  int n_tests = 0, n_fail = 0;
  logic [63:0] qa[$], qb[$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // monitors: compare every transfer against the expected queue, and check masking when idle
  always @(negedge clk) if (rst_n) begin
    if (a_dv && a_dr) begin
      if (qa.size() == 0) chk("a_unexpected_out", a_dd, 64'hx);
      else chk("a_out", a_dd, qa.pop_front());
    end else if (!a_dv) chk("a_mask", a_dd, 64'h0);
  end
  always @(negedge clk) if (rst_n) begin
    if (b_dv && b_dr) begin
      if (qb.size() == 0) chk("b_unexpected_out", b_dd, 64'hx);
      else chk("b_out", b_dd, qb.pop_front());
    end else if (!b_dv) chk("b_mask", b_dd, 64'h0);
  end
  initial begin
    // reset with random stimulus on the main instance
    for (int i = 0; i < 3; i++) begin
      step();
      a_uv = 1'($urandom); a_dr = 1'($urandom); a_flush = 1'($urandom); a_ud = {$urandom, $urandom};
      #3;
      chk("rst_dv", a_dv, 0); chk("rst_dd", a_dd, 0); chk("rst_ur", a_ur, 1);
      chk("rst_occ", a_occ, 0); chk("rst_st", a_st, 0);
    end
    a_uv = 0; a_dr = 0; a_flush = 0; a_ud = '0;
    step(); rst_n = 1;
    // streaming
    step(); a_dr = 1; a_uv = 1; a_ud = 64'h1000_0000_0000_0013; qa.push_back(a_ud);
    step(); a_ud = 64'h1000_0004_0000_0093; qa.push_back(a_ud);
    chk("str_occ0", a_occ, 1); chk("str_ur0", a_ur, 1);
    step(); a_ud = 64'h1000_0008_0000_0113; qa.push_back(a_ud);
    chk("str_occ1", a_occ, 1); chk("str_ur1", a_ur, 1);
    step(); a_uv = 0;
    chk("str_occ2", a_occ, 1); chk("str_ur2", a_ur, 1);
    step();
    chk("str_occ3", a_occ, 0); chk("str_st", a_st, 0);
    // backpressure
    a_dr = 0; a_uv = 1; a_ud = 64'hA; qa.push_back(a_ud);
    step(); a_ud = 64'hB; qa.push_back(a_ud);
    chk("bp_occ1", a_occ, 1); chk("bp_ur1", a_ur, 1);
    step(); a_ud = 64'hC; qa.push_back(a_ud);
    chk("bp_occ2", a_occ, 2); chk("bp_ur2", a_ur, 0); chk("bp_st1", a_st, 1);
    step(); a_dr = 1;
    chk("bp_occ_hold", a_occ, 2); chk("bp_st2", a_st, 2); chk("bp_head", a_dd, 64'hA);
    step();
    chk("bp_occ3", a_occ, 1); chk("bp_ur3", a_ur, 1);
    step(); a_uv = 0;
    chk("bp_occ4", a_occ, 1);
    step();
    chk("bp_occ5", a_occ, 0); chk("bp_st3", a_st, 2); chk("bp_drained", qa.size(), 0);
    // flush while full, with a simultaneous offer of 0xD
    a_dr = 0; a_uv = 1; a_ud = 64'hE; qa.push_back(a_ud);
    step(); a_ud = 64'hF; qa.push_back(a_ud);
    step(); a_ud = 64'hD; a_flush = 1;
    chk("fl_occ_full", a_occ, 2); chk("fl_st_pre", a_st, 3);
    qa.delete();
    step(); a_flush = 0; a_uv = 0;
    chk("fl_dv", a_dv, 0); chk("fl_dd", a_dd, 0); chk("fl_occ", a_occ, 0);
    chk("fl_ur", a_ur, 1); chk("fl_st", a_st, 3);
    a_dr = 1;
    repeat (3) step();
    chk("fl_no_d", a_occ, 0);
    // SKID=0 instance
    b_dr = 0; b_uv = 1; b_ud = 64'h7; qb.push_back(b_ud);
    chk("s0_ur_empty", b_ur, 1);
    step();
    chk("s0_ur_blocked", b_ur, 0); chk("s0_occ1", b_occ, 1); chk("s0_head", b_dd, 64'h7);
    b_dr = 1; b_ud = 64'h5; qb.push_back(b_ud);
    #1 chk("s0_ur_comb", b_ur, 1);
    step(); b_ud = 64'h6; qb.push_back(b_ud);
    chk("s0_occ2", b_occ, 1); chk("s0_repl", b_dd, 64'h5);
    step(); b_uv = 0;
    chk("s0_occ3", b_occ, 1); chk("s0_repl2", b_dd, 64'h6);
    step();
    chk("s0_occ4", b_occ, 0); chk("s0_drained", qb.size(), 0);
    // saturation on the 4-bit counter instance
    c_dr = 0; c_uv = 1; c_ud = 8'h3C;
    step(); c_uv = 0;
    chk("sat_st0", c_st, 0);
    for (int i = 1; i <= 20; i++) begin
      step();
      chk($sformatf("sat_st%0d", i), c_st, (i < 15) ? i : 15);
    end
    chk("sat_head", c_dd, 8'h3C);
    c_dr = 1;
    step();
    chk("sat_occ", c_occ, 0); chk("sat_keep", c_st, 15);
    c_dr = 0;
    // asynchronous reset while full
    a_dr = 0; a_uv = 1; a_ud = 64'h11;
    step(); a_ud = 64'h22;
    step(); a_uv = 0;
    chk("ar_full", a_occ, 2);
    #2 rst_n = 0;
    #1;
    chk("ar_dv", a_dv, 0); chk("ar_dd", a_dd, 0); chk("ar_ur", a_ur, 1);
    chk("ar_occ", a_occ, 0); chk("ar_st", a_st, 0); chk("ar_c_st", c_st, 0);
    qa.delete();
    step(); rst_n = 1;
    step();
    chk("ar_after", a_occ, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised pipeline stage register: successor to the fixed-width IF/ID latch, usable between any two pipeline stages (IF/ID, ID/EX, EX/MEM).
- Replaces the over/allow-in pair with a valid/ready handshake.
- Adds an optional skid entry so upstream ready is registered, plus a flush that inserts a zero bubble and a saturating stall counter for performance monitoring.

Parameters:
- DATA_W, 64: payload width in bits. Default is {pc, inst} = IF2IDBusSize.
- SKID, 1: 1 gives a two-entry buffer with registered up_ready_o; 0 gives a single entry with combinational ready.
- CNT_W, 16: width of the stall counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  discard all held entries (jump/branch taken, exception).
- up_valid_i  in  1  upstream has a payload.
- up_data_i  in  DATA_W  upstream payload.
- up_ready_o  out  1  stage accepts a payload this cycle.
- dn_valid_o  out  1  head entry valid for the downstream stage.
- dn_data_o  out  DATA_W  head payload; 0 when dn_valid_o=0.
- dn_ready_i  in  1  downstream consumes the head this cycle.
- occ_o  out  2  entries held (0..2).
- stall_cnt_o  out  CNT_W  cycles with dn_valid_o=1 and dn_ready_i=0, saturating.

Behaviour:
- Definitions: push = up_valid_i & up_ready_o; pop = dn_valid_o & dn_ready_i.
- Reset (rst_ni=0, takes effect immediately, no clock needed):
  - state EMPTY; main and skid data registers 0.
  - dn_valid_o=0, dn_data_o=0, occ_o=0, stall_cnt_o=0.
  - up_ready_o=1.
- Release of rst_ni is synchronised externally; the block needs no extra handling.
- Latency: a payload pushed at edge N is visible on dn_* after edge N (one cycle). There is no combinational path from up_* to dn_*.
- State machine, SKID=1 (states EMPTY, HALF, FULL; occ_o = 0/1/2):
  - EMPTY: push -> HALF, main<=up_data_i.
  - HALF: push&pop -> HALF, main<=up_data_i. push&!pop -> FULL, skid<=up_data_i. !push&pop -> EMPTY. Otherwise hold.
  - FULL: pop -> HALF, main<=skid. Otherwise hold. No push is possible in FULL.
  - up_ready_o is a flop equal to (next state != FULL). It never depends on dn_ready_i in the same cycle.
- SKID=0:
  - States EMPTY and HALF only; the skid register is absent.
  - up_ready_o = !main_valid | dn_ready_i (combinational).
  - push&pop replaces main in place.
- Ordering: strict FIFO; the skid entry is never presented before main.
- Flush:
  - flush_i=1 at an edge forces state EMPTY and clears main/skid to 0 (bubble).
  - A push in the same cycle is discarded.
  - A pop in the same cycle is still considered performed by downstream; the block takes no extra action.
  - Flush has priority over push, pop and hold.
  - up_ready_o=1 after a flush edge.
- dn_data_o is main masked by dn_valid_o. Stale data never appears on the output.
- Stall counter:
  - Increments each edge where dn_valid_o & !dn_ready_i & !flush_i.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - Cleared only by reset, not by flush.
- Illegal input (up_valid_i deasserted or up_data_i changed before acceptance) is allowed; the block samples only on push.

Test Plan:
- Reset: hold rst_ni=0 with random inputs and clock running -> dn_valid_o=0, dn_data_o=0, up_ready_o=1, occ_o=0, stall_cnt_o=0. Assert rst_ni=0 asynchronously between edges while FULL -> outputs clear before the next edge.
- Streaming: dn_ready_i=1, push 0x1000_0000_0000_0013, 0x1000_0004_0000_0093, 0x1000_0008_0000_0113 on consecutive cycles -> each appears on dn_data_o one cycle later, occ_o stays 1, up_ready_o stays 1, stall_cnt_o=0.
- Backpressure (SKID=1): dn_ready_i=0, push A=0xA, B=0xB, offer C=0xC -> occ_o reaches 2, up_ready_o=0 after B, C held. Raise dn_ready_i -> output sequence A, B, C with no loss or duplicate. stall_cnt_o counts exactly the stalled valid cycles (2 for this timing).
- Flush: in FULL with a simultaneous push of 0xD and flush_i=1 -> next cycle dn_valid_o=0, dn_data_o=0, occ_o=0, up_ready_o=1. 0xD never emerges. stall_cnt_o keeps its value.
- SKID=0 instance: dn_ready_i=0 with main valid -> up_ready_o=0 in the same cycle. dn_ready_i=1 with push of 0x5 -> main replaced, occ_o stays 1, throughput one per cycle.
- Saturation (CNT_W=4): hold dn_valid_o=1, dn_ready_i=0 for 20 cycles -> stall_cnt_o reaches 15 and stays at 15.
